train_sequencer: RTL and testbench

Training-run controller for the DNN. It sequences block cycles of `CPC` clocks and drives the per-clock feed select (`sel_network`) and the training-case select (`sel_tc`) into the input/ideal-output muxes. It counts epochs, stops after a fixed case budget, and scores each case by comparing `a_out` against `y_out` over the valid output cycles. It replaces the testbench-only sequencing with a synthesizable block that sits between the training-data memory and the DNN.

---
 rtl/train_seq_pkg.sv | 22 ++
 rtl/train_sequencer_wrap_counter.sv | 35 +++
 rtl/train_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_train_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/train_seq_pkg.sv
// train_seq_pkg
//   Shared types and width helpers for the training-run sequencer.
//   state_t : run-level FSM state (IDLE, RUN, DONE).
//   feed_of : feed clocks per block cycle (CPC minus the output pipeline delay).
//   cnt_w   : counter width able to hold 0..n-1, never narrower than 1 bit.
package train_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int feed_of(input int cpc, input int pipe_delay);
    return cpc - pipe_delay;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/train_sequencer_wrap_counter.sv
// wrap_counter
//   Modulo-MAX up counter used for the block-cycle position and the
//   training-case select.
//   Parameters: MAX (modulus), WIDTH (count width).
//   Ports:
//     clk, reset : clock, synchronous active-high reset (count -> 0)
//     en         : advance by one this cycle
//     clr        : synchronous clear (lower priority than reset, above en)
//     count      : current value, 0..MAX-1
//     wrap       : combinational, high when en is set and count is MAX-1
module wrap_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/train_sequencer.sv
// train_sequencer
//   Training-run controller. Steps block cycles of CPC clocks, drives the
//   feed-mux select (sel_network) and case select (sel_tc), counts epochs,
//   stops after TRAIN_CASES*EPOCHS cases and scores each case by comparing
//   a_out with y_out on the valid output clocks of the block cycle.
//
//   Optional feature (macro TRAIN_SEQ_ACC_EN): WINDOW-deep correct-case
//   history driving recent_correct. Without the macro recent_correct is 0.
//
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     start           : begin a run (honoured in IDLE or DONE)
//     hold            : freeze sequencing and scoring for this cycle (RUN)
//     a_out, y_out    : DNN output and ideal output, OUT_W bits per clock
//     busy, done      : state is RUN / state is DONE
//     cycle_index     : position in the block cycle
//     cycle_clk       : pulse on the last clock of a block cycle
//     sel_network     : feed-mux select
//     sel_tc          : training-case select
//     epoch           : completed epochs
//     epoch_done      : pulse the cycle after sel_tc wraps
//     tc_error        : last completed case had a mismatch
//     total_error     : errored cases this run (saturating)
//     recent_correct  : correct cases among the last WINDOW cases
//     state_dbg       : raw FSM state for observation
//
//   Handshake: there is no valid/ready pair; start is a level sampled on
//   any edge in IDLE/DONE, and hold is a per-cycle stall with no latency.
module train_sequencer
  import train_seq_pkg::*;
#(
  parameter int CPC         = 18,
  parameter int PIPE_DELAY  = 2,
  parameter int TRAIN_CASES = 10000,
  parameter int EPOCHS      = 10,
  parameter int OUT_W       = 1,
  parameter int WINDOW      = 1000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               hold,
  input  logic [OUT_W-1:0]                   a_out,
  input  logic [OUT_W-1:0]                   y_out,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(CPC)-1:0]             cycle_index,
  output logic                               cycle_clk,
  output logic [$clog2(CPC-PIPE_DELAY)-1:0]  sel_network,
  output logic [$clog2(TRAIN_CASES)-1:0]     sel_tc,
  output logic [$clog2(EPOCHS+1)-1:0]        epoch,
  output logic                               epoch_done,
  output logic                               tc_error,
  output logic [31:0]                        total_error,
  output logic [$clog2(WINDOW+1)-1:0]        recent_correct,
  output logic [1:0]                         state_dbg
);

  localparam int FEED   = feed_of(CPC, PIPE_DELAY);
  localparam int CI_W   = $clog2(CPC);
  localparam int SN_W   = $clog2(FEED);
  localparam int TC_W   = $clog2(TRAIN_CASES);
  localparam int EP_W   = $clog2(EPOCHS + 1);
  localparam int RC_W   = $clog2(WINDOW + 1);
  localparam int BUDGET = TRAIN_CASES * EPOCHS;
  localparam int CC_W   = cnt_w(BUDGET + 1);

  localparam logic [CI_W-1:0] PD_CI     = CI_W'(PIPE_DELAY);
  localparam logic [CI_W-1:0] SN_ADJ    = CI_W'(FEED - PIPE_DELAY);
  localparam logic [CC_W-1:0] LAST_CASE = CC_W'(BUDGET - 1);

  state_t          state, next_state;
  logic            start_run;
  logic            run_en;
  logic            tc_wrap;
  logic            mismatch;
  logic            case_err;
  logic            final_case;
  logic            err_acc;
  logic [CC_W-1:0] case_cnt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)      next_state = RUN;
      RUN:     if (final_case) next_state = DONE;
      DONE:    if (start)      next_state = RUN;
      default:                 next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    run_en    = (state == RUN) && !hold;
    start_run = ((state == IDLE) || (state == DONE)) && start;
    state_dbg = state;
  end

  // ---------------- counters ----------------
  wrap_counter #(.MAX(CPC), .WIDTH(CI_W)) u_cycle (
    .clk   (clk),
    .reset (reset),
    .en    (run_en),
    .clr   (start_run),
    .count (cycle_index),
    .wrap  (cycle_clk)
  );

  wrap_counter #(.MAX(TRAIN_CASES), .WIDTH(TC_W)) u_case (
    .clk   (clk),
    .reset (reset),
    .en    (cycle_clk),
    .clr   (start_run),
    .count (sel_tc),
    .wrap  (tc_wrap)
  );

  // Feed select lags cycle_index by PIPE_DELAY modulo FEED. Both branches
  // produce a value below FEED, so truncating to SN_W bits is exact.
  assign sel_network = (cycle_index >= PD_CI) ? SN_W'(cycle_index - PD_CI)
                                              : SN_W'(cycle_index + SN_ADJ);

  // ---------------- scoring ----------------
  assign mismatch   = run_en && (cycle_index >= PD_CI) && (a_out != y_out);
  // The wrap clock's own comparison is folded in here rather than waiting
  // for the accumulator, which is cleared on that same edge.
  assign case_err   = err_acc | mismatch;
  assign final_case = cycle_clk && (case_cnt == LAST_CASE);

  always_ff @(posedge clk) begin
    if (reset || start_run || cycle_clk) err_acc <= 1'b0;
    else if (mismatch)                   err_acc <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      tc_error    <= 1'b0;
      total_error <= '0;
      epoch       <= '0;
      epoch_done  <= 1'b0;
      case_cnt    <= '0;
    end else begin
      // A held RUN cycle keeps the epoch pulse where it is.
      if (run_en || (state != RUN)) epoch_done <= tc_wrap;
      if (cycle_clk) begin
        tc_error <= case_err;
        if (case_err && (total_error != 32'hFFFF_FFFF))
          total_error <= total_error + 32'd1;
        case_cnt <= case_cnt + CC_W'(1);
      end
      if (tc_wrap) epoch <= epoch + EP_W'(1);
    end
  end

  // ---------------- accuracy window ----------------
`ifdef TRAIN_SEQ_ACC_EN
  logic [WINDOW-1:0] hist;
  logic              new_ok;
  logic              oldest_ok;

  // hist[0] is the newest case; a zero-filled history means the running
  // sum only starts dropping cases once WINDOW cases have completed.
  assign new_ok    = !case_err;
  assign oldest_ok = hist[WINDOW-1];

  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      hist           <= '0;
      recent_correct <= '0;
    end else if (cycle_clk) begin
      for (int i = WINDOW - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= new_ok;
      if (new_ok && !oldest_ok)      recent_correct <= recent_correct + RC_W'(1);
      else if (!new_ok && oldest_ok) recent_correct <= recent_correct - RC_W'(1);
    end
  end
`else
  assign recent_correct = '0;
`endif

endmodule

// File: tb/tb_train_sequencer.sv
module tb_train_sequencer;

  localparam int CPC         = 6;
  localparam int PIPE_DELAY  = 2;
  localparam int TRAIN_CASES = 3;
  localparam int EPOCHS      = 2;
  localparam int OUT_W       = 1;
  localparam int WINDOW      = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset, start, hold;
  logic [OUT_W-1:0] a_out, y_out;

  logic        busy, done, cycle_clk, epoch_done, tc_error;
  logic [2:0]  cycle_index;
  logic [1:0]  sel_network, sel_tc, epoch, state_dbg;
  logic [31:0] total_error;
  logic [2:0]  recent_correct;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  train_sequencer #(
    .CPC(CPC), .PIPE_DELAY(PIPE_DELAY), .TRAIN_CASES(TRAIN_CASES),
    .EPOCHS(EPOCHS), .OUT_W(OUT_W), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .a_out(a_out), .y_out(y_out),
    .busy(busy), .done(done), .cycle_index(cycle_index), .cycle_clk(cycle_clk),
    .sel_network(sel_network), .sel_tc(sel_tc), .epoch(epoch),
    .epoch_done(epoch_done), .tc_error(tc_error), .total_error(total_error),
    .recent_correct(recent_correct), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] sn_tab [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected recent_correct: the hand count when the window is built in.
  function automatic logic [2:0] rc_exp(input int n);
`ifdef TRAIN_SEQ_ACC_EN
    return 3'(n);
`else
    return 3'(n & 0);
`endif
  endfunction

  // Correct cases among the (up to) WINDOW cases completed before case c.
  function automatic int correct_before(input logic [5:0] mask, input int c);
    int n = 0;
    for (int j = ((c > WINDOW) ? c - WINDOW : 0); j < c; j++)
      if (!mask[j]) n++;
    return n;
  endfunction

  task automatic check_all(input string tag, input logic eb, input logic ed,
                           input logic [2:0] eci, input logic ecc,
                           input logic [1:0] esn, input logic [1:0] etc,
                           input logic [1:0] eep, input logic eepd,
                           input logic etce, input logic [31:0] ete,
                           input logic [2:0] erc);
    chk({tag, ".busy"},           busy,           eb);
    chk({tag, ".done"},           done,           ed);
    chk({tag, ".cycle_index"},    cycle_index,    eci);
    chk({tag, ".cycle_clk"},      cycle_clk,      ecc);
    chk({tag, ".sel_network"},    sel_network,    esn);
    chk({tag, ".sel_tc"},         sel_tc,         etc);
    chk({tag, ".epoch"},          epoch,          eep);
    chk({tag, ".epoch_done"},     epoch_done,     eepd);
    chk({tag, ".tc_error"},       tc_error,       etce);
    chk({tag, ".total_error"},    total_error,    ete);
    chk({tag, ".recent_correct"}, recent_correct, erc);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, st, hd, a, y;
    logic        chk;
    logic        busy, done;
    logic [2:0]  ci;
    logic        cclk;
    logic [1:0]  sn, tc, ep;
    logic        epd, tce;
    logic [31:0] te;
    int          rc;
  } vec_t;

  vec_t tbl [10];

  // ---------------- driver: one full run ----------------
  // mask bit c marks case c as errored by a mismatch at cycle err_ci.
  // hold_case: case that stalls at cycle 3 for hold_len clocks (with a
  // mismatch present that must be ignored). rst_case/rst_ci: abort point.
  task automatic do_run(input logic from_done, input logic [5:0] mask,
                        input int err_ci, input int hold_case, input int hold_len,
                        input int rst_case, input int rst_ci);
    int te;
    logic etce;
    reset = 1'b0; start = 1'b1; hold = 1'b0; a_out = 1'b0; y_out = 1'b0;
    #1;
    chk("start.busy", busy, 1'b0);
    chk("start.done", done, from_done);
    @(posedge clk); #1;
    start = 1'b0;
    te = 0;
    for (int c = 0; c < TRAIN_CASES * EPOCHS; c++) begin
      etce = (c == 0) ? 1'b0 : mask[c-1];
      for (int k = 0; k < CPC; k++) begin
        if (c == hold_case && k == 3) begin
          for (int h = 0; h < hold_len; h++) begin
            hold = 1'b1; a_out = 1'b1; y_out = 1'b0;
            #1;
            check_all("hold", 1'b1, 1'b0, 3'(k), 1'b0, sn_tab[k], 2'(c % 3),
                      2'(c / 3), 1'b0, etce, te, rc_exp(correct_before(mask, c)));
            @(posedge clk); #1;
          end
        end
        hold  = 1'b0;
        a_out = (mask[c] && k == err_ci) ? 1'b1 : 1'b0;
        y_out = 1'b0;
        if (c == rst_case && k == rst_ci) reset = 1'b1;
        #1;
        check_all("run", 1'b1, 1'b0, 3'(k), (k == CPC - 1), sn_tab[k], 2'(c % 3),
                  2'(c / 3), (k == 0 && c == TRAIN_CASES), etce, te,
                  rc_exp(correct_before(mask, c)));
        @(posedge clk); #1;
        if (reset) begin
          reset = 1'b0; a_out = 1'b0;
          #1;
          check_all("reset", 1'b0, 1'b0, 3'd0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0,
                    1'b0, 32'd0, 3'd0);
          @(posedge clk); #1;
          return;
        end
      end
      if (mask[c]) te++;
    end
    // DONE: hold and a mismatch are both irrelevant here.
    hold = 1'b1; a_out = 1'b1; y_out = 1'b0;
    #1;
    check_all("done", 1'b0, 1'b1, 3'd0, 1'b0, 2'd2, 2'd0, 2'd2, 1'b1, mask[5], te,
              rc_exp(correct_before(mask, 6)));
    @(posedge clk); #1;
    hold = 1'b0; a_out = 1'b0;
    #1;
    chk("done2.done",        done,        1'b1);
    chk("done2.epoch_done",  epoch_done,  1'b0);
    chk("done2.cycle_index", cycle_index, 3'd0);
    chk("done2.total_error", total_error, te);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    sn_tab = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    //            rst st hd a y chk  busy done ci cclk sn tc ep epd tce te rc
    tbl[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,3'd0,1'b0,2'd2,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[1] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,3'd0,1'b0,2'd2,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[2] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,3'd0,1'b0,2'd2,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[3] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,3'd1,1'b0,2'd3,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,3'd2,1'b0,2'd0,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[5] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,3'd3,1'b0,2'd1,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[6] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,3'd4,1'b0,2'd2,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,3'd5,1'b1,2'd3,2'd0,2'd0,1'b0,1'b0,32'd0,0};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,3'd0,1'b0,2'd2,2'd1,2'd0,1'b0,1'b0,32'd0,1};
    tbl[9] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,3'd0,1'b0,2'd2,2'd0,2'd0,1'b0,1'b0,32'd0,0};

    reset = 1'b1; start = 1'b0; hold = 1'b0; a_out = 1'b0; y_out = 1'b0;
    @(posedge clk); #1;

    // Reset/idle, start latency, sel_network pattern, early-cycle mismatch
    // ignored, start ignored while busy, reset mid-run.
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst; start = tbl[i].st; hold = tbl[i].hd;
      a_out = tbl[i].a;   y_out = tbl[i].y;
      #1;
      if (tbl[i].chk)
        check_all($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].ci,
                  tbl[i].cclk, tbl[i].sn, tbl[i].tc, tbl[i].ep, tbl[i].epd,
                  tbl[i].tce, tbl[i].te, rc_exp(tbl[i].rc));
      @(posedge clk); #1;
    end

    // Clean full run from IDLE.
    do_run(1'b0, 6'b000000, 5, -1, 0, -1, 0);
    // From DONE: error at the last clock of case 2, 3-clock hold in case 1.
    do_run(1'b1, 6'b000100, 5, 1, 3, -1, 0);
    // From DONE: case errors 1,0,0,1,0,0 via the accumulator; total cleared.
    do_run(1'b1, 6'b001001, 4, -1, 0, -1, 0);
    // Reset at cycle 4 of epoch 1, then a fresh run from IDLE.
    do_run(1'b1, 6'b000000, 5, -1, 0, 4, 4);
    do_run(1'b0, 6'b000000, 5, -1, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
